psram_async_ctrl: RTL
=====================

PSRAM_ASYNC_CTRL -- requirements
Module: psram_async_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width; must be a multiple of 8.
REQ-003 SHALL have parameter ACCESS_CYC, default 7, cycles the strobe is held active; must be >= 1.
REQ-004 SHALL have parameter RECOVER_CYC, default 2, chip-deselect cycles between accesses; must be >= 0.
REQ-005 SHALL have a single clock and an asynchronous, active-high reset; ports clk and rst come first.
REQ-006 clk  in  1  system clock, 100 MHz.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 req  in  1  access request; qualified by ready.
REQ-009 we  in  1  1 = write, 0 = read; sampled with req.
REQ-010 addr  in  ADDR_W  word address.
REQ-011 wdata  in  DATA_W  write data.
REQ-012 be  in  DATA_W/8  byte enables, active-high; be[0] = low byte.
REQ-013 ready  out  1  high only in IDLE.
REQ-014 ack  out  1  one-cycle pulse at completion.
REQ-015 rdata  out  DATA_W  read data; valid from ack onward until the next read completes.
REQ-016 MemDB  inout  DATA_W  memory data bus.
REQ-017 MemAdr  out  ADDR_W  memory address.
REQ-018 RamCS, MemOE, MemWR, RamLB, RamUB  out  1 each  active-low memory controls.
REQ-019 RamAdv, RamClk  out  1 each  tied to 0 (asynchronous mode).

Function
REQ-020 FSM states SHALL be IDLE, SETUP, ACCESS, HOLD, RECOVER; all memory outputs SHALL be registered.
REQ-021 IDLE: on req&&ready, SHALL latch we/addr/wdata/be and enter SETUP; ready SHALL drop on the next cycle.
REQ-022 SETUP (1 cycle): MemAdr=addr, RamCS=0, RamLB=~be[0], RamUB=~be[1]; MemOE=0 if read; MemWR=1.
REQ-023 ACCESS (exactly ACCESS_CYC cycles, down-counter): on write, MemWR=0 and MemDB driven with wdata; on read, MemOE=0 and MemDB high-Z.
REQ-024 Read data SHALL be captured into rdata on the clock edge that ends the last ACCESS cycle.
REQ-025 HOLD (1 cycle): MemWR=1, MemOE=1, RamCS=0; on write, MemDB SHALL remain driven (data hold); ack SHALL pulse during HOLD.
REQ-026 RECOVER (RECOVER_CYC cycles): RamCS=1, MemOE=1, MemWR=1, RamLB=RamUB=1, MemDB high-Z; skipped when RECOVER_CYC=0.
REQ-027 ack SHALL assert exactly 2+ACCESS_CYC cycles after the acceptance edge; ready SHALL return 1+RECOVER_CYC cycles after ack.
REQ-028 req while ready=0 SHALL be ignored, with no queuing.
REQ-029 An access with be=0 SHALL still run the full sequence and return ack; both byte lanes SHALL stay deselected.
REQ-030 MemDB SHALL never be driven while MemOE=0.
REQ-031 For DATA_W>16, RamLB/RamUB SHALL follow be[0]/be[1]; upper be bits SHALL gate only the rdata merge.

Reset
REQ-032 rst SHALL force IDLE immediately, including mid-access; RamCS/MemOE/MemWR/RamLB/RamUB=1, MemDB high-Z, ack=0, ready=1 after release, rdata=0, MemAdr=0, counter=0.
REQ-033 An access aborted by reset SHALL produce no ack.

Structure
REQ-034 Package psram_pkg SHALL hold the state enum and the default timing constants (ACCESS_CYC, RECOVER_CYC).
REQ-035 A single sub-module, psram_dq_pad (tristate driver plus input capture), is natural; the counter stays inline.

Verification (ACCESS_CYC=7, RECOVER_CYC=2)
REQ-036 Write: addr=0x000123, wdata=0xBEEF, be=11 -> MemWR low 7 cycles, MemDB=0xBEEF through HOLD, ack at cycle 9.
REQ-037 Read of the same address with the memory model -> rdata=0xBEEF on ack; MemDB never driven by the DUT.
REQ-038 Byte write: be=01, wdata=0x12AB over 0xBEEF -> RamUB=1, RamLB=0; readback returns 0xBEAB.
REQ-039 Back-to-back: req held high for 3 accesses -> accepts spaced 12 cycles apart; req during busy is ignored.
REQ-040 Reset asserted in the 4th ACCESS cycle of a write -> all controls deasserted asynchronously, no ack, next access correct.
REQ-041 RECOVER_CYC=0 build -> ready returns the cycle after ack; RamCS still pulses high for at least 1 cycle between accesses.

Source files
------------

// File: rtl/psram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psram_pkg
//  Description : Shared types and default timing for the asynchronous PSRAM
//                controller: FSM state encoding, default strobe/recovery
//                lengths and a counter-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package psram_pkg;

   // Controller phases of one memory access
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_ACCESS  = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RECOVER = 3'd4
   } state_t;

   // Default strobe length (cycles) and chip-deselect gap (cycles)
   localparam int unsigned DEF_ACCESS_CYC  = 7;
   localparam int unsigned DEF_RECOVER_CYC = 2;

   // The down-counter holds at most max_val-1, so clog2(max_val) bits suffice
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val);
   endfunction

endpackage : psram_pkg
`default_nettype wire

// File: rtl/psram_dq_pad.sv
`default_nettype none
// ============================================================================
//  Module      : psram_dq_pad
//  Description : Data-bus pad for the PSRAM controller. Registers the bus
//                drive enable and write data, and merges the bus value into
//                rdata byte-by-byte under a byte mask when capture is pulsed.
//  Revision    : 1.0  initial release
// ============================================================================
module psram_dq_pad
   import psram_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                drive_d,
   input  logic [DATA_W-1:0]   dout_d,
   input  logic                cap,
   input  logic [DATA_W/8-1:0] cap_be,
   output logic [DATA_W-1:0]   rdata,
   inout  wire  [DATA_W-1:0]   MemDB
);

   localparam int unsigned BE_W = DATA_W / 8;

   logic              drive;
   logic [DATA_W-1:0] dout;

   // Output-enable and write data are registered so the bus switches cleanly on clk
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drive <= 1'b0;
         dout  <= '0;
      end else begin
         drive <= drive_d;
         dout  <= dout_d;
      end
   end

   // Read capture: only enabled byte lanes overwrite the held read data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (cap) begin
         for (int i = 0; i < BE_W; i++) begin
            if (cap_be[i]) begin
               rdata[8*i +: 8] <= MemDB[8*i +: 8];
            end
         end
      end
   end

   assign MemDB = drive ? dout : {DATA_W{1'bz}};

endmodule : psram_dq_pad
`default_nettype wire

// File: rtl/psram_async_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : psram_async_ctrl
//  Description : Single-access controller for an asynchronous-mode PSRAM.
//                Each access runs SETUP -> ACCESS (ACCESS_CYC) -> HOLD ->
//                RECOVER (RECOVER_CYC) -> IDLE. All memory pins are driven
//                from flops whose D inputs are decoded from the next state,
//                so pin timing lines up exactly with the state sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module psram_async_ctrl
   import psram_pkg::*;
#(
   parameter int unsigned ADDR_W      = 23,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ACCESS_CYC  = DEF_ACCESS_CYC,
   parameter int unsigned RECOVER_CYC = DEF_RECOVER_CYC
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req,
   input  logic                we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] be,
   output logic                ready,
   output logic                ack,
   output logic [DATA_W-1:0]   rdata,
   inout  wire  [DATA_W-1:0]   MemDB,
   output logic [ADDR_W-1:0]   MemAdr,
   output logic                RamCS,
   output logic                MemOE,
   output logic                MemWR,
   output logic                RamLB,
   output logic                RamUB,
   output logic                RamAdv,
   output logic                RamClk
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned CNT_W = cnt_width((ACCESS_CYC > RECOVER_CYC) ? ACCESS_CYC : RECOVER_CYC);
   localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYC - 1);
   localparam logic [CNT_W-1:0] REC_LOAD = (RECOVER_CYC > 0) ? CNT_W'(RECOVER_CYC - 1) : '0;

   state_t              state, state_nx;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic                we_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [BE_W-1:0]     be_q;

   logic                accept;
   logic                t_we;
   logic [BE_W-1:0]     t_be;
   logic                be_hi;
   logic                active_nx;
   logic                cs_nx, oe_nx, wr_nx, lb_nx, ub_nx, drive_nx;
   logic                cap;

   assign accept = req && (state == ST_IDLE);
   assign ready  = (state == ST_IDLE);
   assign ack    = (state == ST_HOLD);
   assign RamAdv = 1'b0;
   assign RamClk = 1'b0;

   // On the accept edge the latched copy is not yet loaded, so decode from the inputs
   assign t_we = accept ? we : we_q;
   assign t_be = accept ? be : be_q;

   // Upper lane select exists only when the bus is wider than one byte
   generate
      if (BE_W > 1) begin : g_ub_lane
         assign be_hi = t_be[1];
      end else begin : g_ub_none
         assign be_hi = 1'b0;
      end
   endgenerate

   // State and down-counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state and counter reload; ACCESS and RECOVER count down to zero
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         ST_IDLE: begin
            if (req) state_nx = ST_SETUP;
         end
         ST_SETUP: begin
            state_nx = ST_ACCESS;
            cnt_nx   = ACC_LOAD;
         end
         ST_ACCESS: begin
            if (cnt == '0) state_nx = ST_HOLD;
            else           cnt_nx   = cnt - CNT_W'(1);
         end
         ST_HOLD: begin
            if (RECOVER_CYC == 0) begin
               state_nx = ST_IDLE;
            end else begin
               state_nx = ST_RECOVER;
               cnt_nx   = REC_LOAD;
            end
         end
         ST_RECOVER: begin
            if (cnt == '0) state_nx = ST_IDLE;
            else           cnt_nx   = cnt - CNT_W'(1);
         end
         default: begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // Pin values for the coming cycle, decoded from the next state
   always_comb begin
      active_nx = (state_nx == ST_SETUP) || (state_nx == ST_ACCESS) || (state_nx == ST_HOLD);
      cs_nx     = ~active_nx;
      oe_nx     = ~(~t_we && ((state_nx == ST_SETUP) || (state_nx == ST_ACCESS)));
      wr_nx     = ~(t_we && (state_nx == ST_ACCESS));
      lb_nx     = active_nx ? ~t_be[0] : 1'b1;
      ub_nx     = active_nx ? ~be_hi   : 1'b1;
      drive_nx  = t_we && ((state_nx == ST_ACCESS) || (state_nx == ST_HOLD));
      cap       = ~we_q && (state == ST_ACCESS) && (cnt == '0);
   end

   // Request latch; address goes straight to the pin register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         wdata_q <= '0;
         be_q    <= '0;
         MemAdr  <= '0;
      end else if (accept) begin
         we_q    <= we;
         wdata_q <= wdata;
         be_q    <= be;
         MemAdr  <= addr;
      end
   end

   // Registered active-low memory controls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RamCS <= 1'b1;
         MemOE <= 1'b1;
         MemWR <= 1'b1;
         RamLB <= 1'b1;
         RamUB <= 1'b1;
      end else begin
         RamCS <= cs_nx;
         MemOE <= oe_nx;
         MemWR <= wr_nx;
         RamLB <= lb_nx;
         RamUB <= ub_nx;
      end
   end

   psram_dq_pad #(
      .DATA_W (DATA_W)
   ) u_pad (
      .clk     (clk),
      .rst     (rst),
      .drive_d (drive_nx),
      .dout_d  (wdata_q),
      .cap     (cap),
      .cap_be  (be_q),
      .rdata   (rdata),
      .MemDB   (MemDB)
   );

endmodule : psram_async_ctrl
`default_nettype wire
